// File: rtl/xillybus_mem_regs.sv
// xillybus_mem_regs: seekable 32-bit control/status/scratch bank terminating the Xillybus mem_32 device.
// Word 0 is the control register, word 1 mirrors status_in, words 2..DEPTH-1 are scratch RAM.
module xillybus_mem_regs #(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic        quiesce,
    input  logic [31:0] user_mem_32_addr,
    input  logic        user_mem_32_addr_update,
    input  logic        user_w_mem_32_wren,
    input  logic [31:0] user_w_mem_32_data,
    output logic        user_w_mem_32_full,
    input  logic        user_w_mem_32_open,
    input  logic        user_r_mem_32_rden,
    output logic [31:0] user_r_mem_32_data,
    output logic        user_r_mem_32_empty,
    output logic        user_r_mem_32_eof,
    input  logic        user_r_mem_32_open,
    output logic [31:0] ctrl_reg,
    input  logic [31:0] status_in
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ctrl_q, status_q, rd_q, word;
    logic [ADDR_W:0]   ptr, ptr_nx, ptr_inc;
    logic [ADDR_W-1:0] wa;
    logic              rd_v, at_end, wr_ok, rd_go, chg, unused;

    // A seek combined with a write targets the new address, then steps past it.
    always_comb begin
        at_end  = ptr[ADDR_W];
        ptr_inc = at_end ? ptr : ptr + (ADDR_W+1)'(1);
        rd_go   = user_r_mem_32_rden & rd_v;
        wa      = user_mem_32_addr_update ? user_mem_32_addr[ADDR_W-1:0] : ptr[ADDR_W-1:0];
        wr_ok   = user_w_mem_32_wren & !quiesce & (user_mem_32_addr_update | !at_end);
        ptr_nx  = quiesce ? '0 :
                  user_mem_32_addr_update ? {1'b0, wa} + (ADDR_W+1)'(user_w_mem_32_wren) :
                  (user_w_mem_32_wren | rd_go) ? ptr_inc : ptr;
        chg     = quiesce | user_mem_32_addr_update | user_w_mem_32_wren | rd_go;
        word    = (ptr[ADDR_W-1:0] == '0) ? ctrl_q :
                  (ptr[ADDR_W-1:0] == ADDR_W'(1)) ? status_q : mem[ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            ptr      <= '0;
            rd_v     <= 1'b0;
            rd_q     <= '0;
            ctrl_q   <= CTRL_RST;
            status_q <= '0;
        end else begin
            ptr      <= ptr_nx;
            status_q <= status_in;
            rd_v     <= !chg & !at_end;
            if (!chg && !at_end) rd_q <= word;
            if (wr_ok && wa == '0) ctrl_q <= user_w_mem_32_data;
        end
    end

    // Scratch words carry no reset so they can map onto distributed RAM.
    always_ff @(posedge bus_clk)
        if (wr_ok && wa > ADDR_W'(1)) mem[wa] <= user_w_mem_32_data;

    assign user_w_mem_32_full  = 1'b0;
    assign user_r_mem_32_data  = rd_q;
    assign user_r_mem_32_empty = !rd_v;
    assign user_r_mem_32_eof   = at_end & !rd_v;
    assign ctrl_reg            = ctrl_q;
    assign unused = &{1'b0, user_w_mem_32_open, user_r_mem_32_open, user_mem_32_addr[31:ADDR_W]};
endmodule

// File: tb/tb_xillybus_mem_regs.sv
// tb_xillybus_mem_regs: directed checks of seek, burst access, control/status words, end of memory and quiesce/reset.
module tb_xillybus_mem_regs;
    logic        bus_clk = 1'b0, bus_rst_n = 1'b0, quiesce = 1'b0;
    logic [31:0] user_mem_32_addr = '0, user_w_mem_32_data = '0, status_in = '0;
    logic        user_mem_32_addr_update = 1'b0, user_w_mem_32_wren = 1'b0, user_r_mem_32_rden = 1'b0;
    logic        user_w_mem_32_full, user_r_mem_32_empty, user_r_mem_32_eof;
    logic [31:0] user_r_mem_32_data, ctrl_reg;
    int          n = 0, errs = 0;

    xillybus_mem_regs #(.ADDR_W(5), .CTRL_RST(32'hA5A5_0001)) dut (
        .bus_clk(bus_clk), .bus_rst_n(bus_rst_n), .quiesce(quiesce),
        .user_mem_32_addr(user_mem_32_addr), .user_mem_32_addr_update(user_mem_32_addr_update),
        .user_w_mem_32_wren(user_w_mem_32_wren), .user_w_mem_32_data(user_w_mem_32_data),
        .user_w_mem_32_full(user_w_mem_32_full), .user_w_mem_32_open(1'b1),
        .user_r_mem_32_rden(user_r_mem_32_rden), .user_r_mem_32_data(user_r_mem_32_data),
        .user_r_mem_32_empty(user_r_mem_32_empty), .user_r_mem_32_eof(user_r_mem_32_eof),
        .user_r_mem_32_open(1'b1), .ctrl_reg(ctrl_reg), .status_in(status_in)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic tick;
        @(posedge bus_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic seek(input logic [31:0] a);
        user_mem_32_addr = a;
        user_mem_32_addr_update = 1'b1;
        tick;
        user_mem_32_addr_update = 1'b0;
    endtask

    task automatic wr(input logic [31:0] d);
        user_w_mem_32_data = d;
        user_w_mem_32_wren = 1'b1;
        tick;
        user_w_mem_32_wren = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [31:0] exp);
        tick;
        chk({tag, "_empty"}, 32'(user_r_mem_32_empty), 32'd0);
        chk(tag, user_r_mem_32_data, exp);
        user_r_mem_32_rden = 1'b1;
        tick;
        user_r_mem_32_rden = 1'b0;
        chk({tag, "_gap"}, 32'(user_r_mem_32_empty), 32'd1);
    endtask

    initial begin
        #12;
        chk("rst_ctrl", ctrl_reg, 32'hA5A5_0001);
        chk("rst_empty", 32'(user_r_mem_32_empty), 32'd1);
        chk("rst_eof", 32'(user_r_mem_32_eof), 32'd0);
        chk("rst_full", 32'(user_w_mem_32_full), 32'd0);
        chk("rst_data", user_r_mem_32_data, 32'd0);
        bus_rst_n = 1'b1;
        tick;
        seek(0);
        chk("seek0_empty", 32'(user_r_mem_32_empty), 32'd1);
        tick;
        chk("seek0_empty2", 32'(user_r_mem_32_empty), 32'd0);
        chk("seek0_data", user_r_mem_32_data, 32'hA5A5_0001);
        chk("seek0_full", 32'(user_w_mem_32_full), 32'd0);

        seek(2);
        wr(32'd11);
        wr(32'd22);
        wr(32'd33);
        chk("burst_wptr", 32'(dut.ptr), 32'd5);
        seek(2);
        pop("rd11", 32'd11);
        pop("rd22", 32'd22);
        pop("rd33", 32'd33);
        chk("burst_ptr", 32'(dut.ptr), 32'd5);

        status_in = 32'h0000_CAFE;
        seek(0);
        wr(32'hDEAD_BEEF);
        chk("ctrl_now", ctrl_reg, 32'hDEAD_BEEF);
        wr(32'h0000_1234);
        chk("ctrl_kept", ctrl_reg, 32'hDEAD_BEEF);
        chk("status_wptr", 32'(dut.ptr), 32'd2);
        seek(1);
        pop("status", 32'h0000_CAFE);

        seek(31);
        wr(32'h3131_3131);
        chk("end_ptr", 32'(dut.ptr), 32'd32);
        seek(31);
        pop("rd31", 32'h3131_3131);
        tick;
        chk("end_empty", 32'(user_r_mem_32_empty), 32'd1);
        chk("end_eof", 32'(user_r_mem_32_eof), 32'd1);
        wr(32'h9999_9999);
        chk("end_drop_ptr", 32'(dut.ptr), 32'd32);
        chk("end_eof2", 32'(user_r_mem_32_eof), 32'd1);
        chk("end_full", 32'(user_w_mem_32_full), 32'd0);
        seek(31);
        pop("rd31_again", 32'h3131_3131);
        seek(0);
        chk("wrap_eof", 32'(user_r_mem_32_eof), 32'd0);
        tick;
        chk("wrap_empty", 32'(user_r_mem_32_empty), 32'd0);
        chk("wrap_data", user_r_mem_32_data, 32'hDEAD_BEEF);

        user_mem_32_addr = 32'd7;
        user_w_mem_32_data = 32'd77;
        user_mem_32_addr_update = 1'b1;
        user_w_mem_32_wren = 1'b1;
        tick;
        user_mem_32_addr_update = 1'b0;
        user_w_mem_32_wren = 1'b0;
        chk("sw_ptr", 32'(dut.ptr), 32'd8);
        seek(7);
        pop("rd77", 32'd77);

        seek(9);
        wr(32'd99);
        seek(9);
        tick;
        chk("q_pre_empty", 32'(user_r_mem_32_empty), 32'd0);
        chk("q_pre_data", user_r_mem_32_data, 32'd99);
        quiesce = 1'b1;
        tick;
        quiesce = 1'b0;
        chk("q_empty", 32'(user_r_mem_32_empty), 32'd1);
        chk("q_ptr", 32'(dut.ptr), 32'd0);
        tick;
        chk("q_post_empty", 32'(user_r_mem_32_empty), 32'd0);
        chk("q_post_data", user_r_mem_32_data, 32'hDEAD_BEEF);

        seek(9);
        tick;
        chk("ar_pre_empty", 32'(user_r_mem_32_empty), 32'd0);
        #3 bus_rst_n = 1'b0;
        #1;
        chk("ar_ctrl", ctrl_reg, 32'hA5A5_0001);
        chk("ar_empty", 32'(user_r_mem_32_empty), 32'd1);
        chk("ar_eof", 32'(user_r_mem_32_eof), 32'd0);
        chk("ar_data", user_r_mem_32_data, 32'd0);
        chk("ar_ptr", 32'(dut.ptr), 32'd0);
        #1 bus_rst_n = 1'b1;
        tick;
        chk("ar_post_empty", 32'(user_r_mem_32_empty), 32'd0);
        chk("ar_post_data", user_r_mem_32_data, 32'hA5A5_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/xillybus_mem_regs.md
# xillybus_mem_regs

Seekable 32-bit register/memory bank that terminates the Xillybus `mem_32` device (`user_r_mem_32_*`, `user_w_mem_32_*`, `user_mem_32_addr*`) on the `bus_clk` side of the PCIe wrapper. The host seeks, then reads and writes words through one shared address pointer. Word 0 drives a parallel control register into the fabric. Word 1 is a read-only view of a fabric status input. Words 2..DEPTH-1 are general scratch storage.

## Interface
- `ADDR_W`, default 5; DEPTH = 2^ADDR_W words.
- `CTRL_RST`, default 32'h0000_0000; reset value of word 0.

- `bus_clk`  in  1  sole clock; the Xillybus user clock.
- `bus_rst_n`  in  1  asynchronous active-low reset.
- `quiesce`  in  1  high means the link is down; see Operation.
- `user_mem_32_addr`  in  32  seek address; only bits [ADDR_W-1:0] are used.
- `user_mem_32_addr_update`  in  1  one-cycle strobe; loads the pointer.
- `user_w_mem_32_wren`  in  1  write strobe.
- `user_w_mem_32_data`  in  32  write data.
- `user_w_mem_32_full`  out  1  constant 0.
- `user_w_mem_32_open`  in  1  unused except by the test plan.
- `user_r_mem_32_rden`  in  1  read strobe; honoured only while empty=0.
- `user_r_mem_32_data`  out  32  read data; valid while empty=0.
- `user_r_mem_32_empty`  out  1  read word not yet available.
- `user_r_mem_32_eof`  out  1  pointer is past the last word.
- `user_r_mem_32_open`  in  1  unused.
- `ctrl_reg`  out  32  current content of word 0.
- `status_in`  in  32  sampled into word 1 every cycle.

## Operation
- **Pointer.** `ptr` is ADDR_W+1 bits wide; the value DEPTH means "end".
- **Pointer update priority, per cycle:**
  1. `quiesce` high → ptr=0.
  2. `addr_update` → ptr = addr[ADDR_W-1:0].
  3. `wren` → ptr+1, saturating at DEPTH.
  4. `rden` and !empty → ptr+1, saturating at DEPTH.
- **Writes.** A `wren` with ptr<DEPTH writes mem[ptr], with two exceptions:
  - ptr==1: the write is discarded, but the pointer still advances.
  - ptr==0: the write updates `ctrl_reg`.
- **Writes at end.** A `wren` at ptr==DEPTH is dropped silently. `full` never asserts, so the host can never stall.
- **Read path.** One output register `rd_q` plus a valid flag `rd_v`.
  - `rd_v` clears in any cycle where ptr changes, a write occurs, or `quiesce` is high.
  - Otherwise, if ptr<DEPTH, `rd_q` <= word(ptr) and `rd_v` <= 1.
  - word(1) is the `status_in` value registered in the previous cycle.
- **Output flags.**
  - empty = !rd_v.
  - eof = (ptr==DEPTH) & !rd_v, so eof is asserted only together with empty.
- **Storage.** Words 2..DEPTH-1 are a distributed-RAM array without reset; their content is undefined until written. Word 0 resets to `CTRL_RST`; word 1's status register resets to 0.
- **`addr_update` with `wren` in the same cycle.** The write goes to the new address, then the pointer is new address + 1. This matches Xillybus's seek-then-write ordering.
- **`addr_update` with `rden` in the same cycle.** Not legal: rden implies empty=0, and `addr_update` never coincides with a pending read. If it does occur, `addr_update` wins and the read is not counted.

## Timing
- **Reset values.**
  - `ctrl_reg`=`CTRL_RST`, ptr=0, `rd_v`=0.
  - empty=1, eof=0, full=0, `rd_q`=0.
- **Read latency.** 1 cycle from a ptr change, write, or reset release to empty=0.
- **Throughput.** After `rden` is sampled, empty=1 the next cycle and 0 the cycle after, giving 1 word per 2 cycles.
- **Writes.** 1 word per cycle sustained. `ctrl_reg` updates on the clock edge that samples `wren`.
- **Seek.** `addr_update` on edge N → ptr valid after N; data available (empty=0) after edge N+1.
- **Reset mid-operation.** Asynchronous assert forces all reset values immediately. Deassertion takes effect on the next `bus_clk` edge.
- **Quiesce.** The host link being lost mid-transfer returns ptr to 0. Stored words other than `rd_q` are retained.

## Test plan
- **Reset and default.** Assert `bus_rst_n`=0 with CTRL_RST=32'hA5A5_0001. Release; pulse `addr_update` with addr=0.
  - Expect `ctrl_reg`=A5A5_0001 and full=0 throughout.
  - Expect empty=0 two cycles after the strobe, with data=A5A5_0001.
- **Burst write / read-back.** Seek 2 and write 3 words 11,22,33 on consecutive cycles. Seek 2 and issue `rden` whenever empty=0.
  - Expect reads 11,22,33 at a 2-cycle cadence.
  - Expect ptr=5 at the end.
- **Control and status.** Seek 0 and write 32'hDEAD_BEEF, then 32'h1234 (the second lands on word 1).
  - Expect `ctrl_reg`=DEAD_BEEF.
  - Set `status_in`=32'hCAFE, seek 1 and read: expect CAFE, not 1234.
- **End of memory.** ADDR_W=5: seek 31, read one word.
  - Expect empty=1 and eof=1 thereafter.
  - A `wren` at ptr 32 is dropped: seek 31 and read back the original value.
  - Seek 0: expect eof=0 and empty=0 after 1 cycle.
- **Seek plus write in the same cycle.** `addr_update` with addr=7 together with `wren` data=77, then seek 7 and read.
  - Expect 77.
  - Expect ptr=8 after the combined cycle.
- **Quiesce / reset mid-read.** With empty=0 at ptr=9, raise `quiesce` for 1 cycle.
  - Expect empty=1 and ptr=0.
  - After `quiesce` drops, expect empty=0 with word(0).
  - Repeat with an asynchronous `bus_rst_n` pulse between clock edges: expect outputs at reset values before the next edge.
